// File: rtl/timer_sched.sv
// Shares one down-counter between two level requesters: arbitrate, grant, load, count to zero, done pulse.
// Grant 1 cycle after winning req, done L+2 cycles after it; a req arriving while busy waits on its level, never queued.
module timer_sched #(
    parameter bit  RR_EN   = 1'b1,
    parameter type timer_t = logic [15:0]
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   req_0,
    input  logic   req_1,
    input  logic   abort,
    input  timer_t tmr_val,
    output logic   sel,
    output logic   gnt_0,
    output logic   gnt_1,
    output logic   done_0,
    output logic   done_1,
    output logic   busy,
    output timer_t count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic   sel_q, sel_d;
    logic   last_q, last_d;
    timer_t count_q, count_d;
    logic   winner;

    // last_q resets to 1 so requester 0 takes the first tie under round-robin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    assign winner = (req_0 && req_1) ? (RR_EN ? !last_q : 1'b0) : req_1;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (req_0 || req_1) begin
                    sel_d   = winner;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = tmr_val;
                state_d = (tmr_val == '0) ? S_DONE : S_COUNT;
            end
            S_COUNT: begin
                if (count_q != '0) begin
                    count_d = count_q - timer_t'(1);
                end
                if (count_q <= timer_t'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Cancel overrides every transition; ownership history is left untouched
        if (abort) begin
            state_d = S_IDLE;
            count_d = '0;
            sel_d   = sel_q;
            last_d  = last_q;
        end
    end

    assign sel    = sel_q;
    assign gnt_0  = (state_q == S_LOAD) && !sel_q;
    assign gnt_1  = (state_q == S_LOAD) &&  sel_q;
    assign done_0 = (state_q == S_DONE) && !sel_q;
    assign done_1 = (state_q == S_DONE) &&  sel_q;
    assign busy   = (state_q != S_IDLE);
    assign count  = count_q;

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: round-robin and fixed-priority instances driven in parallel.
module tb_timer_sched;
    typedef logic [15:0] timer_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   req_0 = 1'b0, req_1 = 1'b0, abort = 1'b0;
    timer_t in_0 = '0, in_1 = '0;

    logic   sel_r, g0_r, g1_r, d0_r, d1_r, busy_r;
    logic   sel_f, g0_f, g1_f, d0_f, d1_f, busy_f;
    timer_t cnt_r, cnt_f, tv_r, tv_f;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    assign tv_r = sel_r ? in_1 : in_0;
    assign tv_f = sel_f ? in_1 : in_0;

    timer_sched #(.RR_EN(1'b1), .timer_t(timer_t)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req_0(req_0), .req_1(req_1), .abort(abort),
        .tmr_val(tv_r), .sel(sel_r), .gnt_0(g0_r), .gnt_1(g1_r),
        .done_0(d0_r), .done_1(d1_r), .busy(busy_r), .count(cnt_r));

    timer_sched #(.RR_EN(1'b0), .timer_t(timer_t)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_0(req_0), .req_1(req_1), .abort(abort),
        .tmr_val(tv_f), .sel(sel_f), .gnt_0(g0_f), .gnt_1(g1_f),
        .done_0(d0_f), .done_1(d1_f), .busy(busy_f), .count(cnt_f));

    // Packed view: {sel, busy, gnt_0, gnt_1, done_0, done_1, count}
    function automatic logic [31:0] pk(input logic s, b, g0, g1, d0, d1, input int cnt);
        return {10'd0, s, b, g0, g1, d0, d1, cnt[15:0]};
    endfunction

    function automatic logic [31:0] obs(input int k);
        if (k == 0) return {10'd0, sel_r, busy_r, g0_r, g1_r, d0_r, d1_r, cnt_r};
        return {10'd0, sel_f, busy_f, g0_f, g1_f, d0_f, d1_f, cnt_f};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r0, r1, ab, input timer_t i0, i1);
        @(posedge clk);
        #1;
        req_0 = r0; req_1 = r1; abort = ab; in_0 = i0; in_1 = i1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_0 = 1'b0; req_1 = 1'b0; abort = 1'b0; in_0 = '0; in_1 = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) check("reset_state", obs(k), pk(0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
    endtask

    // Job-timeline reference: a job started at cycle g with load v grants at g,
    // shows v..1 in the following cycles, signals done at g+v+1, then goes idle.
    int  t;
    bit  m_act [2];
    bit  m_sel [2];
    bit  m_last[2];
    int  m_g   [2];
    int  m_v   [2];

    task automatic model_reset();
        t = 0;
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_sel[k] = 0; m_last[k] = 1; m_g[k] = 0; m_v[k] = 0;
        end
    endtask

    function automatic logic [31:0] model_exp(input int k);
        int d;
        d = t - m_g[k];
        if (!m_act[k]) return pk(m_sel[k], 0, 0, 0, 0, 0, 0);
        return pk(m_sel[k], 1, (d == 0) && !m_sel[k], (d == 0) && m_sel[k],
                  (d == m_v[k] + 1) && !m_sel[k], (d == m_v[k] + 1) && m_sel[k],
                  (d >= 1 && d <= m_v[k]) ? m_v[k] - d + 1 : 0);
    endfunction

    task automatic model_upd(input int k, input bit r0, r1, ab, input int i0, i1);
        int d;
        d = t - m_g[k];
        if (m_act[k] && d == 0) m_v[k] = m_sel[k] ? i1 : i0;
        if (ab) begin
            m_act[k] = 0;
        end else if (m_act[k] && d == m_v[k] + 1) begin
            m_act[k]  = 0;
            m_last[k] = m_sel[k];
        end else if (!m_act[k] && (r0 || r1)) begin
            m_sel[k] = (r0 && r1) ? ((k == 0) ? !m_last[k] : 1'b0) : r1;
            m_act[k] = 1;
            m_g[k]   = t + 1;
        end
    endtask

    typedef struct {
        bit          r0, r1, ab;
        timer_t      i0, i1;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[13];

    initial begin
        bit     r0, r1, ab, own;
        timer_t i0, i1;
        int     n_rr, n_fp;
        bit     saw_d0;

        // Single requester 0 with load 5, then requester 1 with load 0
        tbl[0]  = '{1, 0, 0, 5, 0, pk(0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{0, 0, 0, 5, 0, pk(0, 1, 1, 0, 0, 0, 0)};
        tbl[2]  = '{0, 0, 0, 5, 0, pk(0, 1, 0, 0, 0, 0, 5)};
        tbl[3]  = '{0, 0, 0, 5, 0, pk(0, 1, 0, 0, 0, 0, 4)};
        tbl[4]  = '{0, 0, 0, 5, 0, pk(0, 1, 0, 0, 0, 0, 3)};
        tbl[5]  = '{0, 0, 0, 5, 0, pk(0, 1, 0, 0, 0, 0, 2)};
        tbl[6]  = '{0, 0, 0, 5, 0, pk(0, 1, 0, 0, 0, 0, 1)};
        tbl[7]  = '{0, 0, 0, 5, 0, pk(0, 1, 0, 0, 1, 0, 0)};
        tbl[8]  = '{0, 0, 0, 5, 0, pk(0, 0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{0, 1, 0, 9, 0, pk(0, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{0, 0, 0, 9, 0, pk(1, 1, 0, 1, 0, 0, 0)};
        tbl[11] = '{0, 0, 0, 9, 0, pk(1, 1, 0, 0, 0, 1, 0)};
        tbl[12] = '{0, 0, 0, 9, 0, pk(1, 0, 0, 0, 0, 0, 0)};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r0, tbl[i].r1, tbl[i].ab, tbl[i].i0, tbl[i].i1);
            for (int k = 0; k < 2; k++) check($sformatf("table_row%0d_dut%0d", i, k), obs(k), tbl[i].exp);
        end

        // Both requests held: round-robin alternates, fixed priority always picks 0
        do_reset();
        own = 0; n_rr = 0; n_fp = 0;
        for (int c = 0; c < 60; c++) begin
            step(1, 1, 0, 2, 1);
            if (g0_r || g1_r) begin
                check("rr_grant", {30'd0, g1_r, g0_r}, own ? 32'd2 : 32'd1);
                check("rr_sel_at_grant", {31'd0, sel_r}, {31'd0, own});
                own = !own;
                n_rr++;
            end
            if (d0_r || d1_r) check("rr_done_owner", {30'd0, d1_r, d0_r}, own ? 32'd1 : 32'd2);
            if (g0_f || g1_f) begin
                check("fp_grant", {30'd0, g1_f, g0_f}, 32'd1);
                n_fp++;
            end
            if (d0_f || d1_f) check("fp_done_owner", {30'd0, d1_f, d0_f}, 32'd1);
        end
        check("rr_grant_count", {31'd0, n_rr >= 8}, 32'd1);
        check("fp_grant_count", {31'd0, n_fp >= 8}, 32'd1);

        // Abort three cycles into COUNT, waiting requester 1 then served
        do_reset();
        saw_d0 = 0;
        step(1, 0, 0, 100, 3);
        step(0, 1, 0, 100, 3);
        for (int k = 0; k < 2; k++) check("abort_gnt0", obs(k), pk(0, 1, 1, 0, 0, 0, 0));
        step(0, 1, 0, 100, 3);
        step(0, 1, 0, 100, 3);
        step(0, 1, 1, 100, 3);
        for (int k = 0; k < 2; k++) check("abort_cycle", obs(k), pk(0, 1, 0, 0, 0, 0, 98));
        step(0, 1, 0, 100, 3);
        for (int k = 0; k < 2; k++) check("after_abort", obs(k), pk(0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 100, 3);
        for (int k = 0; k < 2; k++) check("abort_then_gnt1", obs(k), pk(1, 1, 0, 1, 0, 0, 0));
        for (int c = 0; c < 3; c++) begin
            step(0, 0, 0, 100, 3);
            saw_d0 = saw_d0 | d0_r | d0_f;
        end
        step(0, 0, 0, 100, 3);
        for (int k = 0; k < 2; k++) check("abort_then_done1", obs(k), pk(1, 1, 0, 0, 0, 1, 0));
        check("no_done0_after_abort", {31'd0, saw_d0}, 32'd0);

        // Asynchronous reset with count at 40, then first tie goes to requester 0
        do_reset();
        step(1, 0, 0, 45, 0);
        step(0, 0, 0, 45, 0);
        repeat (6) step(0, 0, 0, 45, 0);
        for (int k = 0; k < 2; k++) check("count_40", obs(k), pk(0, 1, 0, 0, 0, 0, 40));
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) check("async_reset", obs(k), pk(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 3, 3);
        step(0, 0, 0, 3, 3);
        for (int k = 0; k < 2; k++) check("first_tie_after_reset", obs(k), pk(0, 1, 1, 0, 0, 0, 0));

        // Randomized traffic against the job-timeline reference
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            r0 = ($urandom_range(0, 1) == 1);
            r1 = ($urandom_range(0, 1) == 1);
            ab = ($urandom_range(0, 15) == 0);
            i0 = 16'($urandom_range(0, 6));
            i1 = 16'($urandom_range(0, 6));
            step(r0, r1, ab, i0, i1);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("random_dut%0d_cyc%0d", k, c), obs(k), model_exp(k));
                model_upd(k, r0, r1, ab, int'(i0), int'(i1));
            end
            t++;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
